// File: rtl/alu.sv
// Registered N-bit execute-stage ALU with nine ops, status flags and a 7-seg debug decode.
// Latency: 1 clk from a/b/select to result/flags; led_disp follows result combinationally.
// Backpressure: none; a new operation may be issued every cycle.
//
// Optional feature macro: ALU_DIV_EN. When defined, opcode 0011 is an unsigned
// single-cycle divide (b / a). When undefined, no divider exists and 0011 is a NOP.

module alu #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   select,
   output logic [N-1:0] result,
   output logic [6:0]   led_disp,
   output logic         neg_flag,
   output logic         zero_flag,
   output logic         carry_flag,
   output logic         overflow_flag,
   output logic         nop_flag
);

   // Opcode encodings; everything from 4'h8 upward (and 4'h3 without the divider) is a NOP.
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_SRL = 4'h6;
   localparam logic [3:0] OP_SLL = 4'h7;

   // Shift distance width; any b >= N is handled separately, so only the low bits matter.
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] N_VAL = N'(N);

   // Datapath intermediates
   logic [N:0]     add_full;
   logic [N-1:0]   sub_res;
   logic [2*N-1:0] prod;
   logic           b_big;
   logic [SW-1:0]  sh;
   logic [N:0]     srl_ext;
   logic [N:0]     sll_ext;
`ifdef ALU_DIV_EN
   logic [N-1:0]   quot;
`endif

   // Next-state values for the registered outputs
   logic [N-1:0] result_d, result_q;
   logic         carry_d, carry_q;
   logic         ovf_d, ovf_q;
   logic         nop_d, nop_q;
   logic         neg_d, neg_q;
   logic         zero_d, zero_q;

   // Shared arithmetic and shifter datapaths, computed for every op in parallel.
   always_comb begin
      add_full = {1'b0, a} + {1'b0, b};
      sub_res  = a - b;
      prod     = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      b_big    = (b >= N_VAL);
      sh       = b[SW-1:0];
      // An extra guard bit on the far side of each shift catches the last bit shifted out;
      // with a zero distance the guard stays 0, which is exactly the required carry.
      srl_ext  = {a, 1'b0} >> sh;
      sll_ext  = {1'b0, a} << sh;
   end

`ifdef ALU_DIV_EN
   // Single-cycle combinational divider; divide-by-zero saturates to all ones.
   always_comb begin
      quot = '1;
      if (a != '0) begin
         quot = b / a;
      end
   end
`endif

   // Opcode decode: select the next result and the op-dependent flags.
   always_comb begin
      result_d = '0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      nop_d    = 1'b0;
      case (select)
         OP_ADD: begin
            result_d = add_full[N-1:0];
            carry_d  = add_full[N];
            ovf_d    = (a[N-1] == b[N-1]) && (add_full[N-1] != a[N-1]);
         end
         OP_SUB: begin
            result_d = sub_res;
            carry_d  = (a >= b);
            ovf_d    = (a[N-1] != b[N-1]) && (sub_res[N-1] != a[N-1]);
         end
         OP_MUL: begin
            result_d = prod[N-1:0];
            carry_d  = (prod[2*N-1:N] != '0);
         end
`ifdef ALU_DIV_EN
         OP_DIV: begin
            result_d = quot;
            ovf_d    = (a == '0);
         end
`endif
         OP_AND: begin
            result_d = a & b;
         end
         OP_OR: begin
            result_d = a | b;
         end
         OP_SRL: begin
            if (!b_big) begin
               result_d = srl_ext[N:1];
               carry_d  = srl_ext[0];
            end
         end
         OP_SLL: begin
            if (!b_big) begin
               result_d = sll_ext[N-1:0];
               carry_d  = sll_ext[N];
            end
         end
         default: begin
            nop_d = 1'b1;
         end
      endcase
      neg_d  = result_d[N-1];
      zero_d = (result_d == '0);
   end

   // Result and flag registers; reset shows a clean zero result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         nop_q    <= 1'b0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         nop_q    <= nop_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
      end
   end

   // Active-low hex decode of the registered low nibble (bit0 = seg a ... bit6 = seg g).
   always_comb begin
      led_disp = 7'b1000000;
      case (result_q[3:0])
         4'h0: led_disp = 7'b1000000;
         4'h1: led_disp = 7'b1111001;
         4'h2: led_disp = 7'b0100100;
         4'h3: led_disp = 7'b0110000;
         4'h4: led_disp = 7'b0011001;
         4'h5: led_disp = 7'b0010010;
         4'h6: led_disp = 7'b0000010;
         4'h7: led_disp = 7'b1111000;
         4'h8: led_disp = 7'b0000000;
         4'h9: led_disp = 7'b0010000;
         4'hA: led_disp = 7'b0001000;
         4'hB: led_disp = 7'b0000011;
         4'hC: led_disp = 7'b1000110;
         4'hD: led_disp = 7'b0100001;
         4'hE: led_disp = 7'b0000110;
         4'hF: led_disp = 7'b0001110;
         default: led_disp = 7'b1000000;
      endcase
   end

   assign result        = result_q;
   assign neg_flag      = neg_q;
   assign zero_flag     = zero_q;
   assign carry_flag    = carry_q;
   assign overflow_flag = ovf_q;
   assign nop_flag      = nop_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (N = 32) with hand-computed expected values.
// Each operation is driven, the previous result is confirmed unchanged before the edge,
// and the new result/flags/display are checked 1 ns after the capturing edge.

module tb_alu;

   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   select;
   logic [N-1:0] result;
   logic [6:0]   led_disp;
   logic         neg_flag;
   logic         zero_flag;
   logic         carry_flag;
   logic         overflow_flag;
   logic         nop_flag;

   int n_chk;
   int n_err;
   logic [N-1:0] last_res;

   alu #(.N(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .a             (a),
      .b             (b),
      .select        (select),
      .result        (result),
      .led_disp      (led_disp),
      .neg_flag      (neg_flag),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .nop_flag      (nop_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Active-low segment patterns, typed in from the display table.
   function automatic logic [6:0] seg_of(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   task automatic run_op(input string tag, input logic [3:0] sel, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic [N-1:0] exp_res,
                         input logic exp_c, input logic exp_v, input logic exp_nop);
      select = sel;
      a      = av;
      b      = bv;
      #1;
      chk({tag, ".hold"}, 64'(result), 64'(last_res));
      @(posedge clk);
      #1;
      chk({tag, ".res"},  64'(result),        64'(exp_res));
      chk({tag, ".neg"},  64'(neg_flag),      64'(exp_res[N-1]));
      chk({tag, ".zero"}, 64'(zero_flag),     64'(exp_res == '0));
      chk({tag, ".c"},    64'(carry_flag),    64'(exp_c));
      chk({tag, ".v"},    64'(overflow_flag), 64'(exp_v));
      chk({tag, ".nop"},  64'(nop_flag),      64'(exp_nop));
      chk({tag, ".led"},  64'(led_disp),      64'(seg_of(exp_res[3:0])));
      last_res = exp_res;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".res"},  64'(result),        64'h0);
      chk({tag, ".neg"},  64'(neg_flag),      64'h0);
      chk({tag, ".zero"}, 64'(zero_flag),     64'h1);
      chk({tag, ".c"},    64'(carry_flag),    64'h0);
      chk({tag, ".v"},    64'(overflow_flag), 64'h0);
      chk({tag, ".nop"},  64'(nop_flag),      64'h0);
      chk({tag, ".led"},  64'(led_disp),      64'b1000000);
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      last_res = '0;
      rst      = 1'b1;
      a        = '0;
      b        = '0;
      select   = 4'h0;

      // Reset state before any clock edge.
      #2;
      chk_reset("rst0");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      //      tag        sel    a             b             result        c     v     nop
      run_op("add7p1",   4'h0, 32'h7,        32'h1,        32'h8,        1'b0, 1'b0, 1'b0);
      run_op("addwrap",  4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0);
      run_op("addovf",   4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0);
      run_op("addnegov", 4'h0, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1, 1'b0);
      run_op("sub3m1",   4'h1, 32'h3,        32'h1,        32'h2,        1'b1, 1'b0, 1'b0);
      run_op("sub1m3",   4'h1, 32'h1,        32'h3,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-run, checked before the next clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk_reset("rstmid");
      @(negedge clk);
      rst      = 1'b0;
      last_res = '0;

      run_op("subovf",   4'h1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      run_op("mul2x2",   4'h2, 32'h2,        32'h2,        32'h4,        1'b0, 1'b0, 1'b0);
      run_op("mulhi",    4'h2, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
      run_op("div10by5", 4'h3, 32'h5,        32'hA,        32'h2,        1'b0, 1'b0, 1'b0);
      run_op("divby0",   4'h3, 32'h0,        32'hA,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
`else
      run_op("divnop",   4'h3, 32'h5,        32'hA,        32'h0,        1'b0, 1'b0, 1'b1);
`endif
      run_op("and",      4'h4, 32'hA,        32'h7,        32'h2,        1'b0, 1'b0, 1'b0);
      run_op("or",       4'h5, 32'hA,        32'h5,        32'hF,        1'b0, 1'b0, 1'b0);
      run_op("srl2",     4'h6, 32'hF,        32'h2,        32'h3,        1'b1, 1'b0, 1'b0);
      run_op("srl31",    4'h6, 32'h80000000, 32'd31,       32'h1,        1'b0, 1'b0, 1'b0);
      run_op("srl0",     4'h6, 32'h5,        32'h0,        32'h5,        1'b0, 1'b0, 1'b0);
      run_op("srl32",    4'h6, 32'hFFFFFFFF, 32'd32,       32'h0,        1'b0, 1'b0, 1'b0);
      run_op("sll2",     4'h7, 32'h1,        32'h2,        32'h4,        1'b0, 1'b0, 1'b0);
      run_op("sll1c",    4'h7, 32'hC0000000, 32'h1,        32'h80000000, 1'b1, 1'b0, 1'b0);
      run_op("sll40",    4'h7, 32'hFFFFFFFF, 32'd40,       32'h0,        1'b0, 1'b0, 1'b0);
      run_op("sllbig",   4'h7, 32'h1,        32'h00000100, 32'h0,        1'b0, 1'b0, 1'b0);
      run_op("nop8",     4'h8, 32'hF,        32'hF,        32'h0,        1'b0, 1'b0, 1'b1);
      run_op("addnop",   4'h0, 32'h3,        32'h4,        32'h7,        1'b0, 1'b0, 1'b0);
      run_op("nopF",     4'hF, 32'h7FFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1'b1);
      run_op("orDE",     4'h5, 32'h0000000D, 32'h0,        32'hD,        1'b0, 1'b0, 1'b0);
      run_op("andB",     4'h4, 32'hFFFFFFFB, 32'h8000000F, 32'h8000000B, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
